// File: rtl/time_accum_pkg.sv
// Shared opcodes, FSM states and default sizing for the multi-channel time accumulator.
package time_accum_pkg;
    localparam int DEF_TIME_W   = 18;
    localparam int DEF_MAX_TIME = 86400;

    typedef enum logic [1:0] {
        OP_ADD       = 2'd0,
        OP_SUB       = 2'd1,
        OP_LOAD      = 2'd2,
        OP_SET_ALARM = 2'd3
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;
endpackage

// File: rtl/time_accum_alu.sv
// Combinational add/subtract/clamp for one time value, saturating or modulo MAX_TIME.
module time_accum_alu
    import time_accum_pkg::*;
#(
    parameter int TIME_W   = DEF_TIME_W,
    parameter int MAX_TIME = DEF_MAX_TIME,
    parameter int WRAP     = 0
) (
    input  logic [TIME_W-1:0] value,
    input  logic [TIME_W-1:0] operand,
    input  op_e               op,
    output logic [TIME_W-1:0] result,
    output logic              ovf
);
    localparam logic [TIME_W:0] MAX_W = (TIME_W+1)'(MAX_TIME);
    localparam logic [TIME_W:0] TOP_W = (TIME_W+1)'(MAX_TIME - 1);

    logic [TIME_W:0] val_w, opd_w, sum, opd_mod, diff, res_w;

    always_comb begin
        val_w   = {1'b0, value};
        opd_w   = {1'b0, operand};
        sum     = val_w + opd_w;
        opd_mod = opd_w % MAX_W;
        // value - operand, biased by one period so it never goes negative
        diff    = val_w + (MAX_W - opd_mod);
        res_w   = '0;
        ovf     = 1'b0;
        case (op)
            OP_ADD: begin
                ovf = (sum > TOP_W);
                if (WRAP != 0) res_w = sum % MAX_W;
                else           res_w = ovf ? TOP_W : sum;
            end
            OP_SUB: begin
                ovf = (opd_w > val_w);
                if (WRAP != 0) res_w = (diff >= MAX_W) ? diff - MAX_W : diff;
                else           res_w = ovf ? '0 : val_w - opd_w;
            end
            default: begin
                ovf   = (opd_w > TOP_W);
                res_w = ovf ? TOP_W : opd_w;
            end
        endcase
        result = res_w[TIME_W-1:0];
    end
endmodule

// File: rtl/time_accum_mc.sv
// Multi-channel seconds accumulator: one command port, a shared 1 s tick, CHANNELS counters.
// Per-channel alarms are built only when TIME_ACCUM_ALARM_EN is defined.
module time_accum_mc
    import time_accum_pkg::*;
#(
    parameter int  CHANNELS   = 4,
    parameter int  TIME_W     = DEF_TIME_W,
    parameter int  MAX_TIME   = DEF_MAX_TIME,
    parameter int  START_TIME = 0,
    parameter int  WRAP       = 0,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       TICK,
    input  logic                       CMD_VALID,
    output logic                       CMD_READY,
    input  logic [CH_W-1:0]            CMD_CH,
    input  logic [1:0]                 CMD_OP,
    input  logic [TIME_W-1:0]          CMD_VAL,
    output logic                       RSP_VALID,
    output logic [TIME_W-1:0]          RSP_TIME,
    output logic                       RSP_OVF,
    output logic [CHANNELS*TIME_W-1:0] CURR_TIME,
    output logic [CHANNELS-1:0]        ALARM
);
`ifdef TIME_ACCUM_ALARM_EN
    localparam bit ALARM_BUILT = 1'b1;
`else
    localparam bit ALARM_BUILT = 1'b0;
`endif
    localparam logic [CH_W:0]     CH_LIM = (CH_W+1)'(CHANNELS);
    localparam logic [TIME_W-1:0] TOP    = TIME_W'(MAX_TIME - 1);
    localparam logic [TIME_W-1:0] RST_V  = TIME_W'(START_TIME);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        op_e               op;
        logic [TIME_W-1:0] val;
    } cmd_t;

    state_e              state_q, state_d;
    cmd_t                cmd_q;
    logic [TIME_W-1:0]   ch_q [CHANNELS];
    logic [TIME_W-1:0]   cur_val, alu_res;
    logic                alu_ovf, exec, ch_ok, is_alarm;
    logic [CHANNELS-1:0] wr_en;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (CMD_VALID) state_d = ST_EXEC;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        CMD_READY = (state_q == ST_IDLE);
        RSP_VALID = exec;
        RSP_TIME  = '0;
        RSP_OVF   = 1'b0;
        if (exec) begin
            if (!ch_ok) RSP_OVF = 1'b1;
            else if (!is_alarm || ALARM_BUILT) begin
                RSP_TIME = alu_res;
                RSP_OVF  = alu_ovf;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) cmd_q <= '0;
        else if (state_q == ST_IDLE && CMD_VALID)
            cmd_q <= '{ch: CMD_CH, op: op_e'(CMD_OP), val: CMD_VAL};
    end

    assign exec     = (state_q == ST_EXEC);
    assign ch_ok    = ({1'b0, cmd_q.ch} < CH_LIM);
    assign is_alarm = (cmd_q.op == OP_SET_ALARM);

    always_comb begin
        cur_val = '0;
        for (int n = 0; n < CHANNELS; n++)
            if (cmd_q.ch == CH_W'(n)) cur_val = ch_q[n];
    end

    time_accum_alu #(.TIME_W(TIME_W), .MAX_TIME(MAX_TIME), .WRAP(WRAP)) u_alu (
        .value   (cur_val),
        .operand (cmd_q.val),
        .op      (cmd_q.op),
        .result  (alu_res),
        .ovf     (alu_ovf)
    );

    // A command write wins over the tick for its own channel only.
    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic [TIME_W-1:0] ch_r;
        assign wr_en[n] = exec && ch_ok && !is_alarm && (cmd_q.ch == CH_W'(n));
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET)         ch_r <= RST_V;
            else if (wr_en[n]) ch_r <= alu_res;
            else if (TICK)     ch_r <= (ch_r >= TOP) ? '0 : ch_r + TIME_W'(1);
        end
        assign ch_q[n] = ch_r;
        assign CURR_TIME[n*TIME_W +: TIME_W] = ch_r;
    end

`ifdef TIME_ACCUM_ALARM_EN
    // upd_r marks a fresh channel value; the match is judged one cycle later.
    for (genvar n = 0; n < CHANNELS; n++) begin : g_alm
        logic [TIME_W-1:0] alm_r;
        logic              upd_r, hit_r;
        always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
                alm_r <= '0;
                upd_r <= 1'b0;
                hit_r <= 1'b0;
            end else begin
                if (exec && ch_ok && is_alarm && cmd_q.ch == CH_W'(n)) alm_r <= alu_res;
                upd_r <= wr_en[n] | TICK;
                hit_r <= upd_r && (ch_q[n] == alm_r);
            end
        end
        assign ALARM[n] = hit_r;
    end
`else
    assign ALARM = '0;
`endif
endmodule

// File: tb/tb_time_accum_mc.sv
// Two instances (saturating 4-channel, modulo 3-channel) share one stimulus stream and are
// checked every cycle against a plain-arithmetic model, plus hand-computed spot values.
module tb_time_accum_mc;
    import time_accum_pkg::*;

    localparam int TW      = 18;
    localparam int MAXT    = 86400;
    localparam int NCH_A   = 4;
    localparam int NCH_B   = 3;
    localparam int START_B = 5;
`ifdef TIME_ACCUM_ALARM_EN
    localparam bit ALM_EN = 1'b1;
`else
    localparam bit ALM_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RESET, TICK, CMD_VALID;
    logic [1:0] CMD_CH, CMD_OP;
    logic [TW-1:0] CMD_VAL;
    logic rdy_a, rdy_b, rv_a, rv_b, ovf_a, ovf_b;
    logic [TW-1:0] rt_a, rt_b;
    logic [NCH_A*TW-1:0] ct_a;
    logic [NCH_B*TW-1:0] ct_b;
    logic [NCH_A-1:0] al_a;
    logic [NCH_B-1:0] al_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    time_accum_mc #(.CHANNELS(NCH_A), .TIME_W(TW), .MAX_TIME(MAXT), .START_TIME(0), .WRAP(0)) dut_a (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .CMD_VALID(CMD_VALID), .CMD_READY(rdy_a),
        .CMD_CH(CMD_CH), .CMD_OP(CMD_OP), .CMD_VAL(CMD_VAL), .RSP_VALID(rv_a), .RSP_TIME(rt_a),
        .RSP_OVF(ovf_a), .CURR_TIME(ct_a), .ALARM(al_a));

    time_accum_mc #(.CHANNELS(NCH_B), .TIME_W(TW), .MAX_TIME(MAXT), .START_TIME(START_B), .WRAP(1)) dut_b (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .CMD_VALID(CMD_VALID), .CMD_READY(rdy_b),
        .CMD_CH(CMD_CH), .CMD_OP(CMD_OP), .CMD_VAL(CMD_VAL), .RSP_VALID(rv_b), .RSP_TIME(rt_b),
        .RSP_OVF(ovf_b), .CURR_TIME(ct_b), .ALARM(al_b));

    // ---------------- model ----------------
    int m_ch [2][4];
    int m_alm [2][4];
    bit m_hit [2][4];
    bit m_alarm [2][4];
    bit m_exec;
    int p_ch, p_op, p_val;

    function automatic int nch(input int d);
        return (d == 0) ? NCH_A : NCH_B;
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", nm, d, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int n = 0; n < 4; n++) begin
                m_ch[d][n]    = (d == 0) ? 0 : START_B;
                m_alm[d][n]   = 0;
                m_hit[d][n]   = 1'b0;
                m_alarm[d][n] = 1'b0;
            end
        m_exec = 1'b0;
    endtask

    // Outcome of the pending command on DUT d.
    task automatic model_cmd(input int d, output int r, output bit ovf);
        int cur, s;
        r = 0;
        ovf = 1'b0;
        if (p_ch >= nch(d)) begin
            ovf = 1'b1;
        end else begin
            cur = m_ch[d][p_ch];
            case (p_op)
                0: begin
                    s = cur + p_val;
                    ovf = (s >= MAXT);
                    if (d == 1) r = s % MAXT;
                    else        r = ovf ? MAXT - 1 : s;
                end
                1: begin
                    s = cur - p_val;
                    ovf = (s < 0);
                    if (d == 1) r = ((s % MAXT) + MAXT) % MAXT;
                    else        r = ovf ? 0 : s;
                end
                2: begin
                    ovf = (p_val >= MAXT);
                    r = ovf ? MAXT - 1 : p_val;
                end
                default: if (ALM_EN) begin
                    ovf = (p_val >= MAXT);
                    r = ovf ? MAXT - 1 : p_val;
                end
            endcase
        end
    endtask

    task automatic model_step();
        int r;
        bit ovf;
        int nv [4];
        bit upd [4];
        if (RESET) begin
            model_reset();
            return;
        end
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 4; n++) begin
                nv[n]  = TICK ? (m_ch[d][n] + 1) % MAXT : m_ch[d][n];
                upd[n] = TICK;
            end
            if (m_exec && p_ch < nch(d)) begin
                model_cmd(d, r, ovf);
                if (p_op == 3) m_alm[d][p_ch] = r;
                else begin
                    nv[p_ch]  = r;
                    upd[p_ch] = 1'b1;
                end
            end
            for (int n = 0; n < 4; n++) begin
                m_alarm[d][n] = m_hit[d][n];
                m_hit[d][n]   = ALM_EN && upd[n] && (nv[n] == m_alm[d][n]);
                m_ch[d][n]    = nv[n];
            end
        end
        if (!m_exec && CMD_VALID) begin
            m_exec = 1'b1;
            p_ch   = int'(CMD_CH);
            p_op   = int'(CMD_OP);
            p_val  = int'(CMD_VAL);
        end else begin
            m_exec = 1'b0;
        end
    endtask

    // Every negedge: compare both DUTs with the model, then advance it using the inputs
    // that the next rising edge will sample.
    initial forever begin
        int r;
        bit ovf;
        @(negedge CLK);
        if (RESET) model_reset();
        for (int d = 0; d < 2; d++) begin
            chk("cmd_ready", d, (d == 0) ? rdy_a : rdy_b, !m_exec);
            chk("rsp_valid", d, (d == 0) ? rv_a : rv_b, m_exec);
            if (m_exec) begin
                model_cmd(d, r, ovf);
                chk("rsp_time", d, (d == 0) ? rt_a : rt_b, r);
                chk("rsp_ovf", d, (d == 0) ? ovf_a : ovf_b, ovf);
            end
            for (int n = 0; n < nch(d); n++) begin
                if (d == 0) begin
                    chk($sformatf("curr_time%0d", n), d, ct_a[n*TW +: TW], m_ch[d][n]);
                    chk($sformatf("alarm%0d", n), d, al_a[n], m_alarm[d][n]);
                end else begin
                    chk($sformatf("curr_time%0d", n), d, ct_b[n*TW +: TW], m_ch[d][n]);
                    chk($sformatf("alarm%0d", n), d, al_b[n], m_alarm[d][n]);
                end
            end
        end
        model_step();
    end

    // ---------------- stimulus ----------------
    // Issue one command; optionally tick during its EXEC cycle; pin the responses (-1 skips).
    task automatic cmd(input int ch, input int op, input int val, input bit tk,
                       input int ea, input int eoa, input int eb, input int eob);
        CMD_CH    = 2'(ch);
        CMD_OP    = 2'(op);
        CMD_VAL   = TW'(val);
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        TICK = tk;
        @(negedge CLK);
        if (ea >= 0) begin
            chk("lit_rsp_time", 0, rt_a, ea);
            chk("lit_rsp_ovf", 0, ovf_a, eoa);
        end
        if (eb >= 0) begin
            chk("lit_rsp_time", 1, rt_b, eb);
            chk("lit_rsp_ovf", 1, ovf_b, eob);
        end
        @(posedge CLK);
        #1 TICK = 1'b0;
    endtask

    task automatic tick();
        TICK = 1'b1;
        @(posedge CLK);
        #1 TICK = 1'b0;
    endtask

    initial begin
        int cnt;
        RESET = 1'b1;
        TICK = 1'b0;
        CMD_VALID = 1'b0;
        CMD_CH = '0;
        CMD_OP = '0;
        CMD_VAL = '0;
        @(negedge CLK);
        chk("lit_reset_ch0", 0, ct_a[0 +: TW], 0);
        chk("lit_reset_ch0", 1, ct_b[0 +: TW], START_B);
        chk("lit_reset_rsp", 0, rv_a, 0);
        @(posedge CLK);
        #1 RESET = 1'b0;

        cmd(0, 0, 100, 0, 100, 0, 105, 0);
        chk("lit_ch0_after_add", 0, ct_a[0 +: TW], 100);

        cmd(1, 2, 86000, 0, 86000, 0, 86000, 0);
        cmd(1, 0, 1000, 0, 86399, 1, 600, 1);
        cmd(1, 1, 90000, 0, 0, 1, 83400, 1);

        cmd(2, 2, 86000, 0, 86000, 0, 86000, 0);
        cmd(2, 0, 1000, 0, 86399, 1, 600, 1);
        cmd(2, 1, 700, 0, 85699, 0, 86300, 1);

        cmd(0, 0, 200000, 0, 86399, 1, 27305, 1);
        cmd(0, 2, 90000, 0, 86399, 1, 86399, 1);

        // ch3 is out of range on the 3-channel instance
        cmd(3, 2, 86399, 0, 86399, 0, 0, 1);
        tick();
        chk("lit_ch3_tick_wrap", 0, ct_a[3*TW +: TW], 0);
        chk("lit_ch0_tick_wrap", 1, ct_b[0 +: TW], 0);

        cmd(0, 2, 50, 1, 50, 0, 50, 0);
        chk("lit_ch0_load_wins", 0, ct_a[0 +: TW], 50);
        chk("lit_ch1_ticked", 0, ct_a[1*TW +: TW], 2);
        chk("lit_ch1_ticked", 1, ct_b[1*TW +: TW], 83402);

        cmd(0, 1, 20, 0, 30, 0, 30, 0);

        cmd(0, 3, 10, 0, ALM_EN ? 10 : 0, 0, ALM_EN ? 10 : 0, 0);
        cmd(0, 2, 9, 0, 9, 0, 9, 0);
        tick();
        cnt = 0;
        repeat (4) begin
            @(negedge CLK);
            cnt += int'(al_a[0]);
        end
        chk("lit_alarm0_pulses", 0, cnt, ALM_EN ? 1 : 0);
        @(posedge CLK);
        #1;
        cmd(1, 3, 100000, 0, ALM_EN ? 86399 : 0, ALM_EN ? 1 : 0, ALM_EN ? 86399 : 0, ALM_EN ? 1 : 0);

        // reset lands in the EXEC cycle of this ADD
        CMD_CH = 2'd1;
        CMD_OP = 2'd0;
        CMD_VAL = TW'(5);
        CMD_VALID = 1'b1;
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        RESET = 1'b1;
        @(negedge CLK);
        chk("lit_exec_killed", 0, rv_a, 0);
        chk("lit_exec_killed", 1, rv_b, 0);
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("lit_ready_after_reset", 0, rdy_a, 1);
        chk("lit_ch1_after_reset", 0, ct_a[1*TW +: TW], 0);
        chk("lit_ch1_after_reset", 1, ct_b[1*TW +: TW], START_B);
        @(posedge CLK);
        #1;
        cmd(2, 0, 7, 0, 7, 0, 12, 0);

        repeat (3) @(posedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
